// File: rtl/pkg_mips.sv
// Shared definitions for the MIPS pipeline stages.
//  - ANCHO_DATOS / ANCHO_REG : default data/address and register-index widths
//  - estado_t                : states of the MEM-stage data-memory bus handshake
//  - desalineado()           : true when a byte address is not word aligned
package pkg_mips;

  localparam int ANCHO_DATOS = 32;
  localparam int ANCHO_REG   = 5;

  typedef enum logic {
    LIBRE  = 1'b0,  // no access outstanding
    ESPERA = 1'b1   // request issued, waiting for dmem_ack
  } estado_t;

  function automatic logic desalineado(input logic [1:0] bajos);
    return bajos != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_bus_fsm.sv
// Data-memory bus sequencer for the MEM stage.
// Issues one req/ack transaction per aligned load/store, holds the pipeline
// while it is outstanding and aborts it after TIMEOUT_CICLOS cycles without ack.
// Ports:
//  clk, reset            clock (rising edge), asynchronous active-high reset
//  acceso                load or store present in MEM
//  desal                 that access is misaligned (never reaches the bus)
//  escribir              access is a store (wins over a simultaneous read)
//  dir_palabra           word-aligned address to latch
//  wdato                 store data to latch
//  dmem_ack              bus completion strobe
//  dmem_req/we/dir/wdato registered bus request and its latched attributes
//  stall                 combinational freeze of the upstream pipeline
//  captura               MEM/WB must capture the EX/MEM inputs this edge
//  fin_ok                access completed by ack this cycle (read data valid)
//  excep_desalineado     registered one-cycle pulse, misaligned access
//  error_bus             registered one-cycle pulse, bus timeout
module dmem_bus_fsm #(
  parameter int ANCHO_DATOS    = pkg_mips::ANCHO_DATOS,
  parameter int TIMEOUT_CICLOS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   acceso,
  input  logic                   desal,
  input  logic                   escribir,
  input  logic [ANCHO_DATOS-1:0] dir_palabra,
  input  logic [ANCHO_DATOS-1:0] wdato,
  input  logic                   dmem_ack,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [ANCHO_DATOS-1:0] dmem_dir,
  output logic [ANCHO_DATOS-1:0] dmem_wdato,
  output logic                   stall,
  output logic                   captura,
  output logic                   fin_ok,
  output logic                   excep_desalineado,
  output logic                   error_bus
);
  import pkg_mips::*;

  localparam int                  ANCHO_CNT = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [ANCHO_CNT-1:0] CNT_MAX  = ANCHO_CNT'(TIMEOUT_CICLOS - 1);

  estado_t              estado, estado_next;
  logic [ANCHO_CNT-1:0] cnt, cnt_next;
  logic                 req_next;
  logic                 lanzar;
  logic                 abortar;

  always_comb begin
    estado_next = estado;
    cnt_next    = cnt;
    req_next    = dmem_req;
    lanzar      = 1'b0;
    abortar     = 1'b0;
    stall       = 1'b0;
    captura     = 1'b0;
    fin_ok      = 1'b0;
    case (estado)
      LIBRE: begin
        // An ack arriving here belongs to nothing and is ignored.
        if (!acceso) begin
          captura = 1'b1;
        end else if (!desal) begin
          stall       = 1'b1;
          lanzar      = 1'b1;
          req_next    = 1'b1;
          cnt_next    = '0;
          estado_next = ESPERA;
        end
      end
      ESPERA: begin
        // Ack is tested first so it wins over a coincident timeout.
        if (dmem_ack) begin
          captura     = 1'b1;
          fin_ok      = 1'b1;
          req_next    = 1'b0;
          cnt_next    = '0;
          estado_next = LIBRE;
        end else if (cnt == CNT_MAX) begin
          abortar     = 1'b1;
          req_next    = 1'b0;
          cnt_next    = '0;
          estado_next = LIBRE;
        end else begin
          stall    = 1'b1;
          cnt_next = cnt + ANCHO_CNT'(1);
        end
      end
      default: begin
        estado_next = LIBRE;
        req_next    = 1'b0;
        cnt_next    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado            <= LIBRE;
      cnt               <= '0;
      dmem_req          <= 1'b0;
      dmem_we           <= 1'b0;
      dmem_dir          <= '0;
      dmem_wdato        <= '0;
      excep_desalineado <= 1'b0;
      error_bus         <= 1'b0;
    end else begin
      estado            <= estado_next;
      cnt               <= cnt_next;
      dmem_req          <= req_next;
      excep_desalineado <= (estado == LIBRE) && acceso && desal;
      error_bus         <= abortar;
      if (lanzar) begin
        dmem_we    <= escribir;
        dmem_dir   <= dir_palabra;
        dmem_wdato <= wdato;
      end
    end
  end

endmodule

// File: rtl/etapa_mem_acceso.sv
// MEM stage of the 5-stage MIPS pipeline.
// Takes the EX/MEM buffer outputs, performs loads/stores over a req/ack
// data-memory bus (via dmem_bus_fsm), stalls the pipeline while an access is
// outstanding and registers the results into the MEM/WB buffer. Branch
// resolution is passed straight through to fetch.
// Ports:
//  clk, reset                       clock, asynchronous active-high reset
//  *_MEM                            control/data from EX/MEM
//  dmem_req/we/dir/wdato/rdato/ack  data-memory bus
//  stall_mem                        freeze PC, IF/ID, ID/EX, EX/MEM
//  pc_src, pc_branch                branch decision/target to fetch
//  *_WB                             registered MEM/WB outputs
//  excep_desalineado, error_bus     one-cycle exception pulses
module etapa_mem_acceso #(
  parameter int ANCHO_DATOS    = pkg_mips::ANCHO_DATOS,
  parameter int ANCHO_REG      = pkg_mips::ANCHO_REG,
  parameter int TIMEOUT_CICLOS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   reg_escribir_MEM,
  input  logic                   mem_a_reg_MEM,
  input  logic                   mem_escribir_MEM,
  input  logic                   mem_leer_MEM,
  input  logic                   branch_habilitado_MEM,
  input  logic [ANCHO_DATOS-1:0] branch_target_MEM,
  input  logic [ANCHO_DATOS-1:0] resultado_alu_MEM,
  input  logic [ANCHO_DATOS-1:0] dr2_forward_MEM,
  input  logic [ANCHO_REG-1:0]   registro_destino_MEM,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [ANCHO_DATOS-1:0] dmem_dir,
  output logic [ANCHO_DATOS-1:0] dmem_wdato,
  input  logic [ANCHO_DATOS-1:0] dmem_rdato,
  input  logic                   dmem_ack,
  output logic                   stall_mem,
  output logic                   pc_src,
  output logic [ANCHO_DATOS-1:0] pc_branch,
  output logic                   reg_escribir_WB,
  output logic                   mem_a_reg_WB,
  output logic [ANCHO_DATOS-1:0] dato_leido_WB,
  output logic [ANCHO_DATOS-1:0] resultado_alu_WB,
  output logic [ANCHO_REG-1:0]   registro_destino_WB,
  output logic                   excep_desalineado,
  output logic                   error_bus
);
  import pkg_mips::*;

  logic                   acceso;
  logic                   desal;
  logic                   es_carga;
  logic                   captura;
  logic                   fin_ok;
  logic [ANCHO_DATOS-1:0] dir_palabra;

  assign acceso      = mem_leer_MEM | mem_escribir_MEM;
  assign desal       = acceso & desalineado(resultado_alu_MEM[1:0]);
  // A simultaneous read+write is a store; only a pure read returns data.
  assign es_carga    = mem_leer_MEM & ~mem_escribir_MEM;
  assign dir_palabra = {resultado_alu_MEM[ANCHO_DATOS-1:2], 2'b00};

  assign pc_src    = branch_habilitado_MEM;
  assign pc_branch = branch_target_MEM;

  dmem_bus_fsm #(
    .ANCHO_DATOS    (ANCHO_DATOS),
    .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
  ) u_bus (
    .clk               (clk),
    .reset             (reset),
    .acceso            (acceso),
    .desal             (desal),
    .escribir          (mem_escribir_MEM),
    .dir_palabra       (dir_palabra),
    .wdato             (dr2_forward_MEM),
    .dmem_ack          (dmem_ack),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_dir          (dmem_dir),
    .dmem_wdato        (dmem_wdato),
    .stall             (stall_mem),
    .captura           (captura),
    .fin_ok            (fin_ok),
    .excep_desalineado (excep_desalineado),
    .error_bus         (error_bus)
  );

  // MEM/WB buffer: captures the instruction when it leaves MEM, otherwise
  // loads an all-zero bubble (stall cycles, misaligned access, bus abort).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_escribir_WB     <= 1'b0;
      mem_a_reg_WB        <= 1'b0;
      dato_leido_WB       <= '0;
      resultado_alu_WB    <= '0;
      registro_destino_WB <= '0;
    end else if (captura) begin
      reg_escribir_WB     <= reg_escribir_MEM;
      mem_a_reg_WB        <= mem_a_reg_MEM;
      dato_leido_WB       <= (fin_ok && es_carga) ? dmem_rdato : '0;
      resultado_alu_WB    <= resultado_alu_MEM;
      registro_destino_WB <= registro_destino_MEM;
    end else begin
      reg_escribir_WB     <= 1'b0;
      mem_a_reg_WB        <= 1'b0;
      dato_leido_WB       <= '0;
      resultado_alu_WB    <= '0;
      registro_destino_WB <= '0;
    end
  end

endmodule

// File: tb/tb_etapa_mem_acceso.sv
// Randomised scoreboard bench for etapa_mem_acceso. The driver acts as both
// the EX/MEM buffer and the data memory; for every cycle it pushes the
// expected stall level and the expected MEM/WB contents after that edge.
// A negedge monitor pops and compares them independently.
module tb_etapa_mem_acceso;

  localparam int T = 4;

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic [31:0] dato;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        exc;
    logic        err;
  } wb_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reg_escribir_MEM = 0, mem_a_reg_MEM = 0, mem_escribir_MEM = 0, mem_leer_MEM = 0;
  logic        branch_habilitado_MEM = 0;
  logic [31:0] branch_target_MEM = 0, resultado_alu_MEM = 0, dr2_forward_MEM = 0;
  logic [4:0]  registro_destino_MEM = 0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_dir, dmem_wdato;
  logic [31:0] dmem_rdato = 0;
  logic        dmem_ack = 0;
  logic        stall_mem, pc_src;
  logic [31:0] pc_branch;
  logic        reg_escribir_WB, mem_a_reg_WB;
  logic [31:0] dato_leido_WB, resultado_alu_WB;
  logic [4:0]  registro_destino_WB;
  logic        excep_desalineado, error_bus;

  int errors = 0;
  int checks = 0;

  logic stall_q[$];
  wb_t  wb_q[$];
  logic mon_en = 1'b0;

  etapa_mem_acceso #(.ANCHO_DATOS(32), .ANCHO_REG(5), .TIMEOUT_CICLOS(T)) dut (
    .clk(clk), .reset(reset),
    .reg_escribir_MEM(reg_escribir_MEM), .mem_a_reg_MEM(mem_a_reg_MEM),
    .mem_escribir_MEM(mem_escribir_MEM), .mem_leer_MEM(mem_leer_MEM),
    .branch_habilitado_MEM(branch_habilitado_MEM), .branch_target_MEM(branch_target_MEM),
    .resultado_alu_MEM(resultado_alu_MEM), .dr2_forward_MEM(dr2_forward_MEM),
    .registro_destino_MEM(registro_destino_MEM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_dir(dmem_dir), .dmem_wdato(dmem_wdato),
    .dmem_rdato(dmem_rdato), .dmem_ack(dmem_ack),
    .stall_mem(stall_mem), .pc_src(pc_src), .pc_branch(pc_branch),
    .reg_escribir_WB(reg_escribir_WB), .mem_a_reg_WB(mem_a_reg_WB),
    .dato_leido_WB(dato_leido_WB), .resultado_alu_WB(resultado_alu_WB),
    .registro_destino_WB(registro_destino_WB),
    .excep_desalineado(excep_desalineado), .error_bus(error_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic wb_t wb_now();
    return '{reg_escribir_WB, mem_a_reg_WB, dato_leido_WB, resultado_alu_WB,
             registro_destino_WB, excep_desalineado, error_bus};
  endfunction

  function automatic wb_t cap(input logic rw, input logic m2r, input logic [31:0] d,
                              input logic [31:0] alu, input logic [4:0] rd);
    return '{rw, m2r, d, alu, rd, 1'b0, 1'b0};
  endfunction

  function automatic wb_t bubble(input logic exc, input logic err);
    wb_t b;
    b = '0;
    b.exc = exc;
    b.err = err;
    return b;
  endfunction

  task automatic push(input logic s, input wb_t w);
    stall_q.push_back(s);
    wb_q.push_back(w);
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: stall belongs to the current cycle, WB to the previous edge.
  initial begin
    logic have_prev;
    wb_t  e;
    have_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (have_prev) begin
          e = wb_q.pop_front();
          chk("wb", wb_now(), e);
        end
        if (stall_q.size() > 0) begin
          chk("stall_mem", stall_mem, stall_q.pop_front());
          have_prev = 1'b1;
        end else begin
          have_prev = 1'b0;
        end
      end
    end
  end

  // One instruction through MEM. k = ESPERA cycle (1..T) carrying the ack,
  // 0 = no ack (timeout). late = spurious ack where it must be ignored.
  // Called and returning at posedge+1.
  task automatic run_instr(input logic rw, input logic m2r, input logic wr, input logic rdn,
                           input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                           input int k, input logic late, input logic [31:0] rfix);
    logic        acc, desal, load;
    logic [31:0] rv;
    reg_escribir_MEM     = rw;
    mem_a_reg_MEM        = m2r;
    mem_escribir_MEM     = wr;
    mem_leer_MEM         = rdn;
    resultado_alu_MEM    = alu;
    dr2_forward_MEM      = wd;
    registro_destino_MEM = rd;
    branch_habilitado_MEM = $urandom_range(0, 1);
    branch_target_MEM    = $urandom;
    #0;
    chk("pc_src", pc_src, branch_habilitado_MEM);
    chk("pc_branch", pc_branch, branch_target_MEM);
    acc   = rdn | wr;
    desal = acc && (alu % 4 != 0);
    load  = rdn && !wr;
    if (!acc) begin
      push(1'b0, cap(rw, m2r, 32'h0, alu, rd));
      edge_step();
    end else if (desal) begin
      dmem_ack   = late;
      dmem_rdato = $urandom;
      push(1'b0, bubble(1'b1, 1'b0));
      edge_step();
      dmem_ack = 1'b0;
      chk("req_desal", dmem_req, 1'b0);
    end else begin
      push(1'b1, bubble(1'b0, 1'b0));
      edge_step();
      for (int c = 1; c <= T; c++) begin
        chk("req_hi", dmem_req, 1'b1);
        chk("we", dmem_we, wr);
        chk("dir", dmem_dir, alu & 32'hFFFF_FFFC);
        chk("wdato", dmem_wdato, wd);
        if (c == k) begin
          rv = (rfix != 0) ? rfix : $urandom;
          dmem_ack   = 1'b1;
          dmem_rdato = rv;
          push(1'b0, cap(rw, m2r, load ? rv : 32'h0, alu, rd));
          edge_step();
          dmem_ack = 1'b0;
          break;
        end else if (c == T) begin
          push(1'b0, bubble(1'b0, 1'b1));
          edge_step();
          break;
        end else begin
          push(1'b1, bubble(1'b0, 1'b0));
          edge_step();
        end
      end
      chk("req_lo", dmem_req, 1'b0);
      if (k == 0 && late) begin
        // Late ack after abort, while a NOP sits in MEM.
        reg_escribir_MEM = 0; mem_a_reg_MEM = 0; mem_escribir_MEM = 0; mem_leer_MEM = 0;
        resultado_alu_MEM = 0; dr2_forward_MEM = 0; registro_destino_MEM = 0;
        dmem_ack   = 1'b1;
        dmem_rdato = $urandom;
        push(1'b0, cap(1'b0, 1'b0, 32'h0, 32'h0, 5'd0));
        edge_step();
        dmem_ack = 1'b0;
        chk("req_late", dmem_req, 1'b0);
      end
    end
  endtask

  task automatic idle_inputs();
    reg_escribir_MEM = 0; mem_a_reg_MEM = 0; mem_escribir_MEM = 0; mem_leer_MEM = 0;
    resultado_alu_MEM = 0; dr2_forward_MEM = 0; registro_destino_MEM = 0;
    dmem_ack = 0;
  endtask

  initial begin
    int          kind, k;
    logic [31:0] a;
    // Reset state
    @(negedge clk);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_stall", stall_mem, 1'b0);
    chk("rst_wb", wb_now(), wb_t'(0));
    #7 reset = 1'b0;
    edge_step();
    mon_en = 1'b1;

    // Directed cases
    run_instr(1, 0, 0, 0, 32'h10, 32'h0, 5'd3, 1, 0, 32'h0);               // ALU op
    run_instr(1, 1, 0, 1, 32'h20, 32'h0, 5'd4, 1, 0, 32'hDEADBEEF);         // load, ack 1st
    run_instr(0, 0, 1, 0, 32'h44, 32'h1234, 5'd0, 4, 0, 32'h0);             // store, ack+timeout same cycle
    run_instr(1, 1, 0, 1, 32'h22, 32'h0, 5'd5, 1, 1, 32'h0);                // misaligned load, ack ignored
    run_instr(1, 1, 0, 1, 32'h80, 32'h0, 5'd6, 0, 1, 32'h0);                // timeout + late ack
    run_instr(1, 1, 1, 1, 32'h90, 32'h55AA, 5'd7, 2, 0, 32'h0);             // read+write = write

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 3);
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      k    = $urandom_range(0, T);
      run_instr($urandom_range(0, 1), $urandom_range(0, 1), kind[1], kind[0] | kind[1] & $urandom_range(0, 1),
                a, $urandom, 5'($urandom), k, $urandom_range(0, 1), 32'h0);
    end

    idle_inputs();
    repeat (3) @(negedge clk);
    chk("sb_empty", stall_q.size() + wb_q.size(), 0);
    mon_en = 1'b0;

    // Reset while waiting in ESPERA
    @(posedge clk); #1;
    mem_leer_MEM = 1; reg_escribir_MEM = 1; mem_a_reg_MEM = 1;
    resultado_alu_MEM = 32'h30; registro_destino_MEM = 5'd9;
    edge_step();
    edge_step();
    chk("pre_rst_req", dmem_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_req", dmem_req, 1'b0);
    chk("rst_mid_wb", wb_now(), wb_t'(0));
    idle_inputs();
    #1;
    chk("rst_mid_stall", stall_mem, 1'b0);
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;
    dmem_ack = 1'b1;
    dmem_rdato = 32'hFFFF_0000;
    #1;
    chk("late_ack_stall", stall_mem, 1'b0);
    edge_step();
    dmem_ack = 1'b0;
    chk("late_ack_req", dmem_req, 1'b0);
    chk("late_ack_err", error_bus, 1'b0);
    chk("late_ack_wb", wb_now(), wb_t'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
